// File: rtl/backprop_pkg.sv
// Shared types and width helpers for the z-to-z backprop control path.
package backprop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ACT,
        INIT,
        STREAM,
        DRAIN,
        DONE
    } z2z_state_t;

    function automatic int lw_f(input int max_layers);
        return (max_layers < 1) ? 1 : $clog2(max_layers + 1);
    endfunction

    function automatic int cw_f(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Clearable shift register of {valid, tag} matching the datapath latency.
module valid_delay_line #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             empty_o
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][TAG_W-1:0] t_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            v_q <= '0;
            t_q <= '0;
        end else begin
            v_q[0] <= push_i;
            // Idle slots carry a zero tag so the tail reads 0 when invalid.
            t_q[0] <= push_i ? tag_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                t_q[i] <= t_q[i-1];
            end
        end
    end

    assign valid_o = v_q[DEPTH-1];
    assign tag_o   = t_q[DEPTH-1];
    assign empty_o = ~|v_q;

endmodule

// File: rtl/z_to_z_sequencer.sv
// Per-layer sequencer for the z-to-z backprop datapath: handshakes,
// layer/column bookkeeping and result tagging through the pipe latency.
module z_to_z_sequencer
    import backprop_pkg::*;
#(
    parameter int SIZE         = 3,
    parameter int PIPE_LATENCY = 3 * SIZE - 1,
    parameter int MAX_LAYERS   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [lw_f(MAX_LAYERS)-1:0] layer_count,
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic                        cost_valid,
    output logic                        cost_ready,
    output logic                        set_diff_act,
    output logic                        set_cost,
    output logic                        start_new_layer,
    output logic                        out_valid,
    output logic [cw_f(SIZE)-1:0]       out_col_idx,
    output logic [lw_f(MAX_LAYERS)-1:0] out_layer_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        stream_err
);

    localparam int LW = lw_f(MAX_LAYERS);
    localparam int CW = cw_f(SIZE);
    localparam logic [CW-1:0] COL_LAST = CW'(SIZE - 1);

    z2z_state_t    state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic          err_q, err_d;
    logic          clear;
    logic          dl_valid;
    logic          dl_empty;
    logic [LW-1:0] dl_tag;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        layer_d         = layer_q;
        col_d           = col_q;
        err_d           = err_q;
        clear           = 1'b0;
        act_ready       = 1'b0;
        cost_ready      = 1'b0;
        start_new_layer = 1'b0;
        done            = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (layer_count == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = layer_count;
                        layer_d = '0;
                        state_d = LOAD_ACT;
                    end
                end
            end
            LOAD_ACT: begin
                act_ready = 1'b1;
                if (act_valid) state_d = INIT;
            end
            INIT: begin
                start_new_layer = 1'b1;
                col_d           = '0;
                state_d         = STREAM;
            end
            STREAM: begin
                cost_ready = 1'b1;
                if (cost_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else if (col_q != '0) begin
                    // A gap mid-layer corrupts the systolic stream.
                    err_d   = 1'b1;
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (dl_empty) begin
                    if (layer_q + LW'(1) == cnt_q) begin
                        state_d = DONE;
                    end else begin
                        layer_d = layer_q + LW'(1);
                        state_d = LOAD_ACT;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ocol_d = ocol_q;
        if (clear) begin
            ocol_d = '0;
        end else if (dl_valid) begin
            ocol_d = (ocol_q == COL_LAST) ? '0 : ocol_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            layer_q <= '0;
            col_q   <= '0;
            ocol_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            col_q   <= col_d;
            ocol_q  <= ocol_d;
            err_q   <= err_d;
        end
    end

    assign set_diff_act = act_valid & act_ready;
    assign set_cost     = cost_valid & cost_ready;

    valid_delay_line #(
        .DEPTH(PIPE_LATENCY),
        .TAG_W(LW)
    ) u_dline (
        .clk    (clk),
        .reset  (reset),
        .clear_i(clear),
        .push_i (set_cost),
        .tag_i  (layer_q),
        .valid_o(dl_valid),
        .tag_o  (dl_tag),
        .empty_o(dl_empty)
    );

    assign out_valid     = dl_valid;
    assign out_col_idx   = ocol_q;
    assign out_layer_idx = dl_tag;
    assign busy          = (state_q != IDLE);
    assign stream_err    = err_q;

endmodule

// File: tb/tb_z_to_z_sequencer.sv
// Randomized bench for z_to_z_sequencer against a queue-based reference model.
module tb_z_to_z_sequencer;

    localparam int SIZE = 3;
    localparam int PL   = 3 * SIZE - 1;
    localparam int LW   = 5;
    localparam int CW   = 2;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_INIT   = 2;
    localparam int P_STREAM = 3;
    localparam int P_DRAIN  = 4;
    localparam int P_DONE   = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] layer_count;
    logic          act_valid;
    logic          act_ready;
    logic          cost_valid;
    logic          cost_ready;
    logic          set_diff_act;
    logic          set_cost;
    logic          start_new_layer;
    logic          out_valid;
    logic [CW-1:0] out_col_idx;
    logic [LW-1:0] out_layer_idx;
    logic          busy;
    logic          done;
    logic          stream_err;

    z_to_z_sequencer #(
        .SIZE(SIZE),
        .PIPE_LATENCY(PL),
        .MAX_LAYERS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .layer_count(layer_count),
        .act_valid(act_valid),
        .act_ready(act_ready),
        .cost_valid(cost_valid),
        .cost_ready(cost_ready),
        .set_diff_act(set_diff_act),
        .set_cost(set_cost),
        .start_new_layer(start_new_layer),
        .out_valid(out_valid),
        .out_col_idx(out_col_idx),
        .out_layer_idx(out_layer_idx),
        .busy(busy),
        .done(done),
        .stream_err(stream_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int layer;
    } res_t;

    res_t q[$];
    int   m_ph, m_cnt, m_layer, m_col, m_oc, cyc;
    bit   m_err;

    int n_tests = 0;
    int n_fail  = 0;
    int dn_cnt, ov_cnt, snl_cnt, sc_cnt, sda_cnt;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        m_ph    = P_IDLE;
        m_cnt   = 0;
        m_layer = 0;
        m_col   = 0;
        m_oc    = 0;
        m_err   = 1'b0;
        q.delete();
    endtask

    task automatic step();
        bit e_ov, was_empty;
        #1;
        e_ov = (q.size() > 0) && (q[0].due == cyc);
        check("act_ready", act_ready, m_ph == P_LOAD);
        check("cost_ready", cost_ready, m_ph == P_STREAM);
        check("set_diff_act", set_diff_act, m_ph == P_LOAD && act_valid);
        check("set_cost", set_cost, m_ph == P_STREAM && cost_valid);
        check("start_new_layer", start_new_layer, m_ph == P_INIT);
        check("done", done, m_ph == P_DONE);
        check("busy", busy, m_ph != P_IDLE);
        check("stream_err", stream_err, m_err);
        check("out_valid", out_valid, e_ov);
        if (e_ov) begin
            check("out_col_idx", out_col_idx, m_oc % SIZE);
            check("out_layer_idx", out_layer_idx, q[0].layer);
        end
        dn_cnt  += int'(done);
        ov_cnt  += int'(out_valid);
        snl_cnt += int'(start_new_layer);
        sc_cnt  += int'(set_cost);
        sda_cnt += int'(set_diff_act);
        if (reset) begin
            model_clear();
        end else begin
            was_empty = (q.size() == 0);
            if (e_ov) begin
                void'(q.pop_front());
                m_oc++;
            end
            case (m_ph)
                P_IDLE: if (start) begin
                    m_err = 1'b0;
                    if (layer_count == 0) begin
                        m_ph = P_DONE;
                    end else begin
                        m_cnt   = layer_count;
                        m_layer = 0;
                        m_ph    = P_LOAD;
                    end
                end
                P_LOAD: if (act_valid) m_ph = P_INIT;
                P_INIT: begin
                    m_col = 0;
                    m_ph  = P_STREAM;
                end
                P_STREAM: if (cost_valid) begin
                    q.push_back('{due: cyc + PL, layer: m_layer});
                    m_col++;
                    if (m_col == SIZE) m_ph = P_DRAIN;
                end else if (m_col > 0) begin
                    m_err = 1'b1;
                    q.delete();
                    m_oc = 0;
                    m_ph = P_IDLE;
                end
                P_DRAIN: if (was_empty) begin
                    if (m_layer + 1 == m_cnt) begin
                        m_ph = P_DONE;
                    end else begin
                        m_layer++;
                        m_ph = P_LOAD;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clr_counts();
        dn_cnt  = 0;
        ov_cnt  = 0;
        snl_cnt = 0;
        sc_cnt  = 0;
        sda_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            reset      = 1'b0;
            start      = 1'b0;
            act_valid  = 1'($urandom_range(0, 1));
            cost_valid = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic run(input int count, input int act_wait,
                       input int gap_first, input int drop_after,
                       input bit rst_drain, input bit extra_starts);
        int  wctr = 0;
        int  gctr = 0;
        bit  fin = 1'b0;
        bit  rst_done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            reset = 1'b0;
            start = (k == 0) || (extra_starts && m_ph != P_IDLE &&
                                 $urandom_range(0, 2) == 0);
            layer_count = (k == 0) ? LW'(count)
                                   : LW'($urandom_range(0, 3));
            if (rst_drain && !rst_done && m_ph == P_DRAIN &&
                q.size() == 2) begin
                reset    = 1'b1;
                rst_done = 1'b1;
            end
            if (m_ph == P_LOAD) begin
                act_valid = (wctr >= act_wait);
                wctr++;
            end else begin
                wctr      = 0;
                act_valid = 1'($urandom_range(0, 1));
            end
            if (m_ph == P_STREAM && m_col == 0) begin
                cost_valid = (gctr >= gap_first);
                gctr++;
            end else if (m_ph == P_STREAM) begin
                cost_valid = !(drop_after > 0 && m_col == drop_after);
            end else begin
                gctr       = 0;
                cost_valid = 1'($urandom_range(0, 1));
            end
            step();
            if (m_ph == P_IDLE) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) check("run_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        layer_count = '0;
        act_valid   = 1'b0;
        cost_valid  = 1'b0;
        cyc         = 0;
        model_clear();
        clr_counts();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_col", out_col_idx, 0);
        check("rst_layer", out_layer_idx, 0);
        check("rst_err", stream_err, 0);
        @(negedge clk);
        idle(2);

        clr_counts();
        run(1, 1, 0, 0, 1'b0, 1'b0);
        idle(3);
        check("t1_sda", sda_cnt, 1);
        check("t1_snl", snl_cnt, 1);
        check("t1_sc", sc_cnt, 3);
        check("t1_ov", ov_cnt, 3);
        check("t1_done", dn_cnt, 1);
        check("t1_busy", busy, 0);

        clr_counts();
        run(3, 0, 0, 0, 1'b0, 1'b0);
        idle(3);
        check("t2_snl", snl_cnt, 3);
        check("t2_ov", ov_cnt, 9);
        check("t2_done", dn_cnt, 1);

        clr_counts();
        run(2, 0, 0, 1, 1'b0, 1'b0);
        idle(12);
        check("t3_err", stream_err, 1);
        check("t3_sc", sc_cnt, 1);
        check("t3_ov", ov_cnt, 0);
        check("t3_done", dn_cnt, 0);
        run(1, 0, 0, 0, 1'b0, 1'b0);
        check("t3_err_clr", stream_err, 0);
        idle(3);

        clr_counts();
        run(1, 0, 0, 0, 1'b1, 1'b0);
        check("t4_busy", busy, 0);
        check("t4_col", out_col_idx, 0);
        check("t4_layer", out_layer_idx, 0);
        check("t4_ov", out_valid, 0);
        clr_counts();
        idle(12);
        check("t4_ov_after", ov_cnt, 0);

        clr_counts();
        run(2, 0, 0, 0, 1'b0, 1'b1);
        idle(3);
        check("t5_done", dn_cnt, 1);
        clr_counts();
        run(0, 0, 0, 0, 1'b0, 1'b0);
        idle(3);
        check("t5z_done", dn_cnt, 1);
        check("t5z_sc", sc_cnt, 0);
        check("t5z_sda", sda_cnt, 0);
        check("t5z_snl", snl_cnt, 0);

        clr_counts();
        run(2, 5, 4, 0, 1'b0, 1'b0);
        idle(3);
        check("t6_done", dn_cnt, 1);
        check("t6_err", stream_err, 0);
        check("t6_ov", ov_cnt, 6);

        clr_counts();
        run(16, 0, 0, 0, 1'b0, 1'b0);
        idle(3);
        check("max_ov", ov_cnt, 48);
        check("max_done", dn_cnt, 1);

        for (int r = 0; r < 30; r++) begin
            run($urandom_range(0, 5), $urandom_range(0, 4),
                $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, SIZE - 1)
                                            : 0,
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 12));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
